// File: rtl/packet_fifo_pkg.sv
// rtl/packet_fifo_pkg.sv - pointer width and modulo pointer arithmetic helpers for packet_fifo
// Purpose: shared helpers so every pointer in the FIFO uses one width rule
//          and one wrap-aware subtraction.
// Ports:   none (package).
package packet_fifo_pkg;

    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_wide_t;

    // Pointers carry one extra bit beyond the RAM address so that a full
    // FIFO (difference == DEPTH) is distinguishable from an empty one.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // a - b modulo 2**pw; callers zero-extend their pointers into ptr_wide_t.
    function automatic ptr_wide_t ptr_diff(input ptr_wide_t a, input ptr_wide_t b, input int pw);
        ptr_wide_t mask;
        mask = (ptr_wide_t'(1) << pw) - ptr_wide_t'(1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/packet_fifo_ram.sv
// rtl/packet_fifo_ram.sv - DATA_W x DEPTH storage with one write port and a registered read port
// Purpose: storage array for packet_fifo. The array itself is never reset;
//          only the read register is.
// Ports:   clk, rst (sync, active-high, read register only),
//          we/waddr/wdata (write port), re/raddr (read request),
//          rdata (registered read word, holds when re is low).
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/packet_fifo.sv
// rtl/packet_fifo.sv - packet-aware FIFO with commit/rollback on write and release/replay on read
// Purpose: buffers a word stream between two bridge sides. The writer
//          publishes whole packets with write_commit or abandons them with
//          write_error; the reader frees space with read_done or replays the
//          current packet with read_error.
// Ports:   clk, rst (sync, active-high), clear (sync flush),
//          write_enable/write_data/write_start/write_commit/write_error,
//          read_enable/read_start/read_done/read_error, read_data,
//          fifo_empty, fifo_full, used_count, free_count, overflow, underflow.
module packet_fifo
    import packet_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_start,
    input  logic              write_commit,
    input  logic              write_error,
    input  logic              read_enable,
    input  logic              read_start,
    input  logic              read_done,
    input  logic              read_error,
    output logic [DATA_W-1:0] read_data,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [AW:0]       used_count,
    output logic [AW:0]       free_count,
    output logic              overflow,
    output logic              underflow
);

    typedef logic [ptr_width(DEPTH)-1:0] ptr_t;

    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

    ptr_t wr_ptr_q, wr_ptr_d, wr_mark_q, wr_mark_d, wr_cmt_q, wr_cmt_d;
    ptr_t rd_ptr_q, rd_ptr_d, rd_mark_q, rd_mark_d;
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    ptr_t wr_span;
    logic wr_acc, rd_acc, flush;
    ptr_t wr_post, rd_post;

    assign flush = rst | clear;

    // Space is counted against the released read mark, so words that were
    // read but not yet released by read_done still occupy the FIFO.
    assign wr_span    = ptr_t'(ptr_diff(ptr_wide_t'(wr_ptr_q), ptr_wide_t'(rd_mark_q), ptr_width(DEPTH)));
    assign fifo_full  = (wr_span == DEPTH_P);
    assign fifo_empty = (rd_ptr_q == wr_cmt_q);
    assign used_count = ptr_t'(ptr_diff(ptr_wide_t'(wr_cmt_q), ptr_wide_t'(rd_ptr_q), ptr_width(DEPTH)));
    assign free_count = DEPTH_P - wr_span;

    // Error inputs cancel the access outright; a cancelled access is not a
    // rejected one, so it does not count toward overflow/underflow.
    assign wr_acc  = write_enable & ~write_error & ~fifo_full & ~flush;
    assign rd_acc  = read_enable & ~read_error & ~fifo_empty & ~flush;
    assign wr_post = wr_ptr_q + ptr_t'(wr_acc);
    assign rd_post = rd_ptr_q + ptr_t'(rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_mark_d   = wr_mark_q;
        wr_cmt_d    = wr_cmt_q;
        overflow_d  = 1'b0;
        if (write_error) begin
            wr_ptr_d = wr_mark_q;
        end else begin
            wr_ptr_d   = wr_post;
            overflow_d = write_enable & fifo_full;
            if (write_start) begin
                wr_mark_d = wr_ptr_q;
            end
            // A word written alongside write_start opens the next packet, so
            // it must stay invisible even if write_commit closes the old one.
            if (write_commit) begin
                wr_cmt_d = write_start ? wr_ptr_q : wr_post;
            end
        end
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        rd_mark_d   = rd_mark_q;
        underflow_d = 1'b0;
        if (read_error) begin
            rd_ptr_d = rd_mark_q;
        end else begin
            rd_ptr_d    = rd_post;
            underflow_d = read_enable & fifo_empty;
            if (read_start) begin
                rd_mark_d = rd_ptr_q;
            end
            if (read_done) begin
                rd_mark_d = rd_post;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q    <= '0;
            wr_mark_q   <= '0;
            wr_cmt_q    <= '0;
            rd_ptr_q    <= '0;
            rd_mark_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            wr_mark_q   <= wr_mark_d;
            wr_cmt_q    <= wr_cmt_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_mark_q   <= rd_mark_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (flush),
        .we    (wr_acc),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (write_data),
        .re    (rd_acc),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (read_data)
    );

endmodule

// File: tb/tb_packet_fifo.sv
// tb/tb_packet_fifo.sv - directed self-checking bench for packet_fifo
module tb_packet_fifo;

    logic       clk = 1'b0;
    logic       rst, clear;
    logic       write_enable, write_start, write_commit, write_error;
    logic [7:0] write_data;
    logic       read_enable, read_start, read_done, read_error;
    logic [7:0] read_data;
    logic       fifo_empty, fifo_full, overflow, underflow;
    logic [4:0] used_count, free_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    packet_fifo #(.DATA_W(8), .DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .write_enable (write_enable),
        .write_data   (write_data),
        .write_start  (write_start),
        .write_commit (write_commit),
        .write_error  (write_error),
        .read_enable  (read_enable),
        .read_start   (read_start),
        .read_done    (read_done),
        .read_error   (read_error),
        .read_data    (read_data),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .used_count   (used_count),
        .free_count   (free_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; clear = 1'b0;
        write_enable = 1'b0; write_data = 8'h00; write_start = 1'b0;
        write_commit = 1'b0; write_error = 1'b0;
        read_enable = 1'b0; read_start = 1'b0; read_done = 1'b0; read_error = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d, input logic s, input logic c);
        idle();
        write_enable = 1'b1; write_data = d; write_start = s; write_commit = c;
        tick();
    endtask

    task automatic rd(input logic s, input logic d);
        idle();
        read_enable = 1'b1; read_start = s; read_done = d;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", fifo_empty); end
        n_cmp++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", fifo_full); end
        n_cmp++; if (free_count !== 5'd16) begin n_fail++; $display("FAIL reset_free got %0d want 16", free_count); end
        n_cmp++; if (used_count !== 5'd0) begin n_fail++; $display("FAIL reset_used got %0d want 0", used_count); end
        n_cmp++; if (read_data !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h want 00", read_data); end
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got %b want 00", {overflow, underflow}); end
    endtask

    task automatic test_single_word();
        // start+commit with the write: the word opens a new packet and stays hidden
        wr(8'hFF, 1'b1, 1'b1);
        n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL sw_hidden_empty got %b want 1", fifo_empty); end
        n_cmp++; if (free_count !== 5'd15) begin n_fail++; $display("FAIL sw_free got %0d want 15", free_count); end
        idle(); write_commit = 1'b1; tick();
        n_cmp++; if (used_count !== 5'd1) begin n_fail++; $display("FAIL sw_used got %0d want 1", used_count); end
        n_cmp++; if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL sw_visible got %b want 0", fifo_empty); end
        rd(1'b1, 1'b1);
        n_cmp++; if (read_data !== 8'hFF) begin n_fail++; $display("FAIL sw_rdata got %h want ff", read_data); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL sw_empty_after got %b want 1", fifo_empty); end
        n_cmp++; if (free_count !== 5'd16) begin n_fail++; $display("FAIL sw_free_after got %0d want 16", free_count); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) wr(8'(i), i == 0, i == 15);
        n_cmp++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", fifo_full); end
        n_cmp++; if (free_count !== 5'd0) begin n_fail++; $display("FAIL fill_free got %0d want 0", free_count); end
        wr(8'hAA, 1'b0, 1'b0);
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow got %b want 1", overflow); end
        n_cmp++; if (used_count !== 5'd16) begin n_fail++; $display("FAIL fill_used got %0d want 16", used_count); end
        idle(); tick();
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_overflow_pulse got %b want 0", overflow); end
        for (int i = 0; i < 16; i++) begin
            rd(i == 0, i == 15);
            n_cmp++; if (read_data !== 8'(i)) begin n_fail++; $display("FAIL fill_drain[%0d] got %h want %h", i, read_data, 8'(i)); end
        end
        rd(1'b0, 1'b0);
        n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL fill_underflow got %b want 1", underflow); end
        n_cmp++; if (read_data !== 8'h0F) begin n_fail++; $display("FAIL fill_rdata_hold got %h want 0f", read_data); end
    endtask

    task automatic test_write_rollback();
        for (int i = 0; i < 8; i++) wr(8'(i), i == 0, i == 7);
        for (int i = 8; i < 14; i++) wr(8'(i), i == 8, 1'b0);
        idle();
        write_enable = 1'b1; write_data = 8'h55; write_commit = 1'b1; write_error = 1'b1;
        tick();
        n_cmp++; if (used_count !== 5'd8) begin n_fail++; $display("FAIL rb_used got %0d want 8", used_count); end
        n_cmp++; if (free_count !== 5'd8) begin n_fail++; $display("FAIL rb_free got %0d want 8", free_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rb_overflow got %b want 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            rd(i == 0, i == 7);
            n_cmp++; if (read_data !== 8'(i)) begin n_fail++; $display("FAIL rb_read[%0d] got %h want %h", i, read_data, 8'(i)); end
        end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rb_empty got %b want 1", fifo_empty); end
    endtask

    task automatic test_read_replay();
        // pointers sit at 25 here, so this packet wraps the 5-bit pointers
        for (int i = 8; i < 15; i++) wr(8'(i), i == 8, i == 14);
        for (int i = 0; i < 3; i++) begin
            rd(i == 0, 1'b0);
            n_cmp++; if (read_data !== 8'(8 + i)) begin n_fail++; $display("FAIL rp_first[%0d] got %h want %h", i, read_data, 8'(8 + i)); end
        end
        idle(); read_enable = 1'b1; read_done = 1'b1; read_error = 1'b1; tick();
        n_cmp++; if (read_data !== 8'd10) begin n_fail++; $display("FAIL rp_hold got %h want 0a", read_data); end
        n_cmp++; if (used_count !== 5'd7) begin n_fail++; $display("FAIL rp_used got %0d want 7", used_count); end
        n_cmp++; if (free_count !== 5'd9) begin n_fail++; $display("FAIL rp_free got %0d want 9", free_count); end
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                n_cmp++; if (free_count !== 5'd9) begin n_fail++; $display("FAIL rp_free_before_done got %0d want 9", free_count); end
            end
            rd(1'b0, i == 6);
            n_cmp++; if (read_data !== 8'(8 + i)) begin n_fail++; $display("FAIL rp_replay[%0d] got %h want %h", i, read_data, 8'(8 + i)); end
        end
        n_cmp++; if (free_count !== 5'd16) begin n_fail++; $display("FAIL rp_free_done got %0d want 16", free_count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 15; i++) wr(8'(8'h30 + i), i == 0, i == 14);
        n_cmp++; if (used_count !== 5'd15) begin n_fail++; $display("FAIL bb_used_pre got %0d want 15", used_count); end
        idle();
        write_enable = 1'b1; write_data = 8'h77; write_commit = 1'b1;
        read_enable = 1'b1; read_start = 1'b1; read_done = 1'b1;
        tick();
        n_cmp++; if (read_data !== 8'h30) begin n_fail++; $display("FAIL bb_rdata got %h want 30", read_data); end
        n_cmp++; if (used_count !== 5'd15) begin n_fail++; $display("FAIL bb_used got %0d want 15", used_count); end
        n_cmp++; if ({fifo_full, fifo_empty, overflow, underflow} !== 4'b0000) begin n_fail++; $display("FAIL bb_flags got %b want 0000", {fifo_full, fifo_empty, overflow, underflow}); end
        for (int i = 1; i < 16; i++) begin
            rd(1'b0, 1'b1);
            n_cmp++; if (read_data !== ((i == 15) ? 8'h77 : 8'(8'h30 + i))) begin n_fail++; $display("FAIL bb_drain[%0d] got %h want %h", i, read_data, (i == 15) ? 8'h77 : 8'(8'h30 + i)); end
        end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL bb_empty got %b want 1", fifo_empty); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) wr(8'(8'hC0 + i), i == 0, i == 2);
        for (int i = 3; i < 5; i++) wr(8'(8'hC0 + i), i == 3, 1'b0);
        idle(); clear = 1'b1; write_enable = 1'b1; write_data = 8'hEE; tick();
        n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL clr_empty got %b want 1", fifo_empty); end
        n_cmp++; if (free_count !== 5'd16) begin n_fail++; $display("FAIL clr_free got %0d want 16", free_count); end
        n_cmp++; if (used_count !== 5'd0) begin n_fail++; $display("FAIL clr_used got %0d want 0", used_count); end
        n_cmp++; if (read_data !== 8'h00) begin n_fail++; $display("FAIL clr_rdata got %h want 00", read_data); end
        wr(8'h5A, 1'b0, 1'b1);
        rd(1'b1, 1'b1);
        n_cmp++; if (read_data !== 8'h5A) begin n_fail++; $display("FAIL clr_reuse got %h want 5a", read_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_single_word();
        test_fill();
        test_write_rollback();
        test_read_replay();
        test_back_to_back();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
